// File: rtl/fifo_rd_drain_pkg.sv
// Shared types and default sizing for the FIFO read-side drain block.
package fifo_rd_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/rd_skid_buf.sv
// Small circular buffer between the FIFO head and the downstream port.
// Head entry is always visible on data_out; entries reset to zero.
module rd_skid_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     rclk,
    input  logic                     rreset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    cnt_reg;

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (push) begin
            mem_reg[tail_reg] <= data_in;
        end
    end

    // DEPTH is a power of two, so pointer arithmetic wraps on its own.
    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            head_reg <= '0;
            tail_reg <= '0;
            cnt_reg  <= '0;
        end else begin
            head_reg <= head_reg + PW'(pop);
            tail_reg <= tail_reg + PW'(push);
            cnt_reg  <= cnt_reg + CW'(push) - CW'(pop);
        end
    end

    assign data_out = mem_reg[head_reg];
    assign cnt      = cnt_reg;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain consumer: pops a first-word-fall-through FIFO into a local
// buffer, presents words downstream, and supports a clean enable/flush stop.
module fifo_rd_drain
    import fifo_rd_drain_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             rclk,
    input  logic             rreset,
    input  logic             en,
    input  logic             empty,
    input  logic [WIDTH-1:0] rdata,
    output logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             idle,
    output logic [CNT_W-1:0] pop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    drain_state_t     state_reg;
    drain_state_t     state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             drain;
    logic [CNT_W-1:0] pop_cnt_reg;

    rd_skid_buf #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .rclk     (rclk),
        .rreset   (rreset),
        .push     (pop),
        .data_in  (rdata),
        .pop      (drain),
        .data_out (out_data),
        .cnt      (cnt)
    );

    // pop is independent of out_ready, so no ready-to-pop combinational path.
    assign out_valid = (cnt != '0);
    assign drain     = out_valid & out_ready;
    assign pop       = (state_reg == RUN) & ~empty & (cnt < CW'(DEPTH));
    assign cnt_next  = cnt + CW'(pop) - CW'(drain);

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (en) state_next = RUN;
            RUN:     if (!en) state_next = FLUSH;
            FLUSH: begin
                if (en) begin
                    state_next = RUN;
                end else if (cnt_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        idle = (state_reg == IDLE);
    end

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            pop_cnt_reg <= '0;
        end else if (pop) begin
            pop_cnt_reg <= pop_cnt_reg + CNT_W'(1);
        end
    end

    assign pop_cnt = pop_cnt_reg;

endmodule
